// File: rtl/instr_sequencer_if.sv
// Host-side push bus and issue-side outputs of the instruction sequencer.
// Widths follow the FIFO depth and the drop-counter width of the attached sequencer.
interface instr_sequencer_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [9:0]        in_instr;
    logic [9:0]        Instruc;
    logic [1:0]        phase;
    logic              issue_valid;
    logic [CW-1:0]     count;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output in_valid, in_instr,
        input  in_ready, Instruc, phase, issue_valid, count, drop_cnt
    );

    modport slave (
        input  in_valid, in_instr,
        output in_ready, Instruc, phase, issue_valid, count, drop_cnt
    );
endinterface

// File: rtl/instr_sequencer.sv
// Buffers host cache instructions in a FIFO and issues exactly one per 4-step bus
// transaction, holding it stable for the whole window and exporting the step phase.
module instr_sequencer #(
    parameter int unsigned DEPTH      = 8,
    parameter logic [9:0]  IDLE_INSTR = 10'h180,
    parameter int unsigned DROP_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    instr_sequencer_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [1:0]        r_phase;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [9:0]        r_mem [DEPTH];
    logic [9:0]        r_instr;
    logic              r_issue_valid;
    logic [DROP_W-1:0] r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_legal;
    logic w_push;
    logic w_drop;
    logic w_boundary;
    logic w_pop;

    // Pointers carry a wrap bit: equal means empty, differing only in the wrap bit means full.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_accept   = bus.in_valid & ~w_full;
    assign w_legal    = ~bus.in_instr[8];
    assign w_push     = w_accept & w_legal;
    assign w_drop     = w_accept & ~w_legal;
    assign w_boundary = (r_phase == 2'd3);
    assign w_pop      = w_boundary & ~w_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase       <= 2'd0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_instr       <= IDLE_INSTR;
            r_issue_valid <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_phase <= r_phase + 2'd1;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            // The issue decision sees pre-edge occupancy, so a same-edge push waits a window.
            if (w_boundary) begin
                if (w_pop) begin
                    r_instr       <= r_mem[r_rptr[AW-1:0]];
                    r_issue_valid <= 1'b1;
                    r_rptr        <= r_rptr + PW'(1);
                end else begin
                    r_instr       <= IDLE_INSTR;
                    r_issue_valid <= 1'b0;
                end
            end
            if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= bus.in_instr;
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.count       = r_wptr - r_rptr;
    assign bus.Instruc     = r_instr;
    assign bus.phase       = r_phase;
    assign bus.issue_valid = r_issue_valid;
    assign bus.drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: a behavioural queue model plus a scoreboard of hand-computed
// issue words, checked by a negedge monitor independently of the stimulus.
`timescale 1ns/1ps
module tb_instr_sequencer;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_sequencer_if #(.DEPTH(DEPTH), .DROP_W(8)) bus ();
    instr_sequencer_if #(.DEPTH(DEPTH), .DROP_W(2)) bus2 ();

    instr_sequencer #(.DEPTH(DEPTH), .IDLE_INSTR(10'h180), .DROP_W(8)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    instr_sequencer #(.DEPTH(DEPTH), .IDLE_INSTR(10'h180), .DROP_W(2)) u_dut2 (
        .clock (clk),
        .reset (rst),
        .bus   (bus2.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Hand-computed scoreboard of words expected on Instruc, in issue order.
    logic [9:0] hq[$];

    // Behavioural reference model.
    logic [9:0] mdl_q[$];
    int         mdl_phase = 0;
    logic [9:0] mdl_instr = 10'h180;
    bit         mdl_iv    = 1'b0;
    int         mdl_drop  = 0;
    bit         mdl_acc   = 1'b0;
    bit         mdl_full  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_q.delete();
            mdl_phase = 0;
            mdl_instr = 10'h180;
            mdl_iv    = 1'b0;
            mdl_drop  = 0;
            mdl_acc   = 1'b0;
        end else begin
            mdl_full = (mdl_q.size() >= DEPTH);
            mdl_acc  = bus.in_valid && !mdl_full;
            if (mdl_phase == 3) begin
                if (mdl_q.size() > 0) begin
                    mdl_instr = mdl_q.pop_front();
                    mdl_iv    = 1'b1;
                end else begin
                    mdl_instr = 10'h180;
                    mdl_iv    = 1'b0;
                end
            end
            if (mdl_acc) begin
                if (bus.in_instr[8] == 1'b0) mdl_q.push_back(bus.in_instr);
                else if (mdl_drop < 255) mdl_drop++;
            end
            mdl_phase = (mdl_phase + 1) % 4;
        end
    end

    // Monitor: compare every output against the model, and pop the scoreboard on each issue.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mon_phase", 32'(bus.phase), mdl_phase);
            chk("mon_instr", 32'(bus.Instruc), 32'(mdl_instr));
            chk("mon_issue_valid", 32'(bus.issue_valid), 32'(mdl_iv));
            chk("mon_count", 32'(bus.count), mdl_q.size());
            chk("mon_in_ready", 32'(bus.in_ready), (mdl_q.size() < DEPTH) ? 1 : 0);
            chk("mon_drop_cnt", 32'(bus.drop_cnt), mdl_drop);
            if (bus.phase == 2'd0 && bus.issue_valid) begin
                if (hq.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected_issue: got 0x%0h expected no issue at %0t",
                             bus.Instruc, $time);
                end else begin
                    chk("sb_issue", 32'(bus.Instruc), 32'(hq.pop_front()));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Drives one word for exactly one edge; exp=1 adds it to the expected issue order.
    task automatic push(input logic [9:0] w, input bit exp);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        if (exp) hq.push_back(w);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        hq.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        bit  got;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 10'h000;
        bus2.in_valid = 1'b0;
        bus2.in_instr = 10'h000;

        // Reset then idle
        do_reset();
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_drop", 32'(bus.drop_cnt), 0);
        chk("rst_instr", 32'(bus.Instruc), 32'h180);
        chk("rst_phase", 32'(bus.phase), 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("idle_phase", 32'(bus.phase), k % 4);
            chk("idle_instr", 32'(bus.Instruc), 32'h180);
            chk("idle_valid", 32'(bus.issue_valid), 0);
        end

        // Ordered issue
        do_reset();
        push(10'h005, 1'b1);
        push(10'h0A3, 1'b1);
        cyc(); cyc();
        chk("ord_first", 32'(bus.Instruc), 32'h005);
        chk("ord_first_v", 32'(bus.issue_valid), 1);
        repeat (4) cyc();
        chk("ord_second", 32'(bus.Instruc), 32'h0A3);
        repeat (4) cyc();
        chk("ord_idle", 32'(bus.Instruc), 32'h180);
        chk("ord_idle_v", 32'(bus.issue_valid), 0);

        // Illegal proc, including an illegal push on a popping boundary
        do_reset();
        push(10'h100, 1'b0);
        push(10'h180, 1'b0);
        chk("ill_drop2", 32'(bus.drop_cnt), 2);
        chk("ill_count", 32'(bus.count), 0);
        push(10'h041, 1'b1);
        push(10'h1FF, 1'b0);
        chk("ill_pop_count", 32'(bus.count), 0);
        chk("ill_pop_drop", 32'(bus.drop_cnt), 3);
        chk("ill_pop_instr", 32'(bus.Instruc), 32'h041);
        repeat (8) cyc();

        // Narrow drop counter saturates
        bus2.in_valid = 1'b1;
        bus2.in_instr = 10'h100;
        cyc(); cyc();
        chk("sat_drop2", 32'(bus2.drop_cnt), 2);
        repeat (3) cyc();
        bus2.in_valid = 1'b0;
        chk("sat_drop_max", 32'(bus2.drop_cnt), 3);
        chk("sat_count", 32'(bus2.count), 0);

        // Boundary race
        do_reset();
        repeat (3) cyc();
        push(10'h011, 1'b1);
        chk("race_idle", 32'(bus.Instruc), 32'h180);
        chk("race_idle_v", 32'(bus.issue_valid), 0);
        chk("race_count", 32'(bus.count), 1);
        repeat (4) cyc();
        chk("race_issue", 32'(bus.Instruc), 32'h011);
        chk("race_issue_v", 32'(bus.issue_valid), 1);
        repeat (4) cyc();

        // Full FIFO with continuous pushing
        do_reset();
        w = 1;
        bus.in_instr = 10'(w);
        bus.in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            cyc();
            if (mdl_acc) begin
                hq.push_back(10'(w));
                w++;
                bus.in_instr = 10'(w);
            end
            if (!bus.in_ready) got = 1'b1;
        end
        chk("full_reached", 32'(got), 1);
        chk("full_count", 32'(bus.count), 8);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            cyc();
            if (mdl_acc) begin
                hq.push_back(10'(w));
                w++;
                bus.in_instr = 10'(w);
            end
            if (bus.count != 4'd8) got = 1'b1;
        end
        chk("full_pop_seen", 32'(got), 1);
        chk("full_pop_count", 32'(bus.count), 7);
        chk("full_pop_ready", 32'(bus.in_ready), 1);
        cyc();
        if (mdl_acc) begin
            hq.push_back(10'(w));
            w++;
        end
        bus.in_valid = 1'b0;
        chk("full_refill_count", 32'(bus.count), 8);
        chk("full_refill_ready", 32'(bus.in_ready), 0);
        repeat (48) cyc();
        chk("full_drained", 32'(bus.count), 0);

        // Mid-window asynchronous reset
        do_reset();
        push(10'h005, 1'b1);
        push(10'h013, 1'b1);
        push(10'h024, 1'b1);
        push(10'h035, 1'b1);
        chk("mid_queued", 32'(bus.count), 3);
        cyc(); cyc();
        chk("mid_phase", 32'(bus.phase), 2);
        chk("mid_instr", 32'(bus.Instruc), 32'h005);
        rst = 1'b1;
        hq.delete();
        #1;
        chk("mid_rst_instr", 32'(bus.Instruc), 32'h180);
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_phase", 32'(bus.phase), 0);
        chk("mid_rst_valid", 32'(bus.issue_valid), 0);
        rst = 1'b0;
        repeat (16) cyc();

        chk("sb_drain", hq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
